morra_giocatore: RTL
====================

# morra_giocatore

Automatic two-player move sequencer for the MorraCinese referee. It drives the referee's PRIMO/SECONDO/INIZIO inputs and reads back its MANCHE/PARTITA outputs. It plays complete games autonomously from pseudo-random move streams, respecting the no-repeat rule for the previous round's winner. It reports the final result, the valid-round count and a timeout flag. It serves as the on-chip opponent/exerciser sitting in front of the referee.

## Interface
- SEED1, 8'hA5, initial LFSR value for player 1 (a value of 0 is replaced by 8'h01)
- SEED2, 8'h3C, initial LFSR value for player 2 (a value of 0 is replaced by 8'h01)
- MAX_MANCHE, 15, valid-round cap before timeout (1..15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- AVVIA  in  1  start-game request, sampled in IDLE/DONE
- MANCHE  in  2  referee round result: 00 invalid/none, 01 P1 wins, 10 P2 wins, 11 tie
- PARTITA  in  2  referee game result: 00 ongoing, 01 P1, 10 P2, 11 draw
- PRIMO  out  2  player-1 move: 00 none, 01 sasso, 10 carta, 11 forbice
- SECONDO  out  2  player-2 move, same encoding
- INIZIO  out  1  referee game-reset strobe
- FINE  out  1  game finished, held until next start
- VINCITORE  out  2  final PARTITA value latched at end (00 on timeout)
- N_MANCHE  out  4  count of valid rounds (MANCHE != 00) in the current game
- TIMEOUT  out  1  game ended because MAX_MANCHE was reached with PARTITA == 00

## Operation
- States: IDLE, START, PLAY, CHECK, DONE. All outputs are registered.
- IDLE: all outputs 0. AVVIA=1 -> START.
- START (1 cycle): INIZIO=1, PRIMO=SECONDO=00. Clears N_MANCHE, FINE, VINCITORE, TIMEOUT and the last-move/last-winner registers. Next state: PLAY.
- PLAY (1 cycle): both LFSRs advance one step. Each candidate move = (new LFSR value mod 3)+1, driven on PRIMO/SECONDO. Next state: CHECK.
- LFSR: 8-bit Galois, right shift. If bit0=1, next = (v>>1) ^ 8'hB8; otherwise next = v>>1.
- No-repeat rule: if the previous valid MANCHE named a player the winner and that player's candidate equals its previous move, the move is rotated 01->10->11->01. The loser and tie cases are unconstrained.
- CHECK (1 cycle): PRIMO=SECONDO=00. The referee ignores 00 moves and holds its state. MANCHE/PARTITA are sampled at the end of CHECK; they reflect the moves from PLAY.
  - If MANCHE != 00: N_MANCHE increments, and the winner register and previous moves are updated.
  - If MANCHE == 00: the round does not count and the registers are unchanged.
  - If PARTITA != 00: VINCITORE<=PARTITA, FINE<=1, go to DONE.
  - Else if N_MANCHE (after increment) == MAX_MANCHE: TIMEOUT<=1, FINE<=1, VINCITORE<=00, go to DONE.
  - Otherwise go to PLAY.
- DONE: moves 00, INIZIO 0. FINE/VINCITORE/N_MANCHE/TIMEOUT are held. AVVIA=1 -> START.
- AVVIA is ignored in START/PLAY/CHECK. LFSR state persists across games; it is reloaded only by reset.
- N_MANCHE is 4-bit and saturates at 15. It never wraps.

## Timing
- rst_n low at any time, including mid-game: immediately state=IDLE, all outputs 0, LFSRs = seeds. The first start is accepted on the first rising edge with rst_n high and AVVIA=1.
- AVVIA sampled high at edge k -> INIZIO high during cycle k+1 -> first moves during cycle k+2.
- One round = 2 cycles (PLAY, CHECK). The referee result for PLAY moves is sampled at the edge ending CHECK.
- FINE rises on the edge ending the deciding CHECK cycle. The minimum game-end latency from AVVIA is 2+2·N cycles for N rounds.
- AVVIA held high continuously restarts immediately after each DONE (one DONE cycle).

## Test plan
- Reset: hold rst_n=0 with AVVIA=1 -> all outputs 0. Release rst_n, drive AVVIA for 1 cycle -> INIZIO=1 for exactly one cycle, moves 00.
- Default seeds, first round -> LFSR1 0xA5->0xEA (234 mod 3=0) and LFSR2 0x3C->0x1E (30 mod 3=0), so PRIMO=01 and SECONDO=01 in the first PLAY cycle, then 00/00 in CHECK.
- Bench returns MANCHE=01 with the P1 move 01 -> next PLAY PRIMO != 01 for every round in which P1's candidate would repeat. Check 50 rounds against a bench model of the LFSR and rotate rule.
- Bench returns MANCHE=00 for three rounds, then 11 -> N_MANCHE=1, and the winner rule is not applied after the invalid rounds.
- Bench returns PARTITA=10 on the 4th valid round -> FINE=1, VINCITORE=10, N_MANCHE=4, TIMEOUT=0, moves 00 and held. A new AVVIA clears these in START.
- MAX_MANCHE=3 with PARTITA always 00 -> FINE=1, TIMEOUT=1, VINCITORE=00, N_MANCHE=3. Asserting rst_n low mid-PLAY -> outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/morra_giocatore_if.sv
// morra_giocatore_if: signal bundle between the move sequencer and the
// referee side (referee or bench).
//   avvia      start-game request                (referee side -> player)
//   manche     referee round result              (referee side -> player)
//   partita    referee game result               (referee side -> player)
//   primo      player-1 move                     (player -> referee side)
//   secondo    player-2 move                     (player -> referee side)
//   inizio     referee game-reset strobe         (player -> referee side)
//   fine       game finished, held               (player -> referee side)
//   vincitore  latched final result              (player -> referee side)
//   n_manche   valid-round count                 (player -> referee side)
//   timeout    game ended on round cap           (player -> referee side)
// modport master: the sequencer; modport slave: the referee/bench side.
interface morra_giocatore_if;
  logic       avvia;
  logic [1:0] manche;
  logic [1:0] partita;
  logic [1:0] primo;
  logic [1:0] secondo;
  logic       inizio;
  logic       fine;
  logic [1:0] vincitore;
  logic [3:0] n_manche;
  logic       timeout;

  modport master (
    input  avvia, manche, partita,
    output primo, secondo, inizio, fine, vincitore, n_manche, timeout
  );

  modport slave (
    output avvia, manche, partita,
    input  primo, secondo, inizio, fine, vincitore, n_manche, timeout
  );
endinterface

// File: rtl/morra_giocatore.sv
// morra_giocatore: autonomous two-player move sequencer for the MorraCinese
// referee. Plays full games from per-player 8-bit Galois LFSR streams,
// enforcing the no-repeat rule for the previous round's winner, and reports
// the result, the valid-round count and a timeout flag.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    morra_giocatore_if.master (avvia/manche/partita in,
//          primo/secondo/inizio/fine/vincitore/n_manche/timeout out)
// Parameters: SEED1/SEED2 initial LFSR values (0 -> 8'h01),
//             MAX_MANCHE valid-round cap (1..15).

// One player lane: owns the LFSR and produces the candidate move for the
// next PLAY cycle, already rotated when the no-repeat rule applies.
module morra_lfsr_player #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,        // step the LFSR (entering PLAY)
  input  logic       hold_rule,  // this player won the last valid round
  input  logic [1:0] prev_mv,    // this player's move in that round
  output logic [1:0] mv
);
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] cand;

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);
    // move is derived from the value the LFSR is about to take
    cand   = 2'(lfsr_d % 8'd3) + 2'd1;
    mv     = cand;
    if (hold_rule && cand == prev_mv)
      mv = (cand == 2'b11) ? 2'b01 : cand + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   lfsr_q <= SEED_EFF;
    else if (adv) lfsr_q <= lfsr_d;
  end
endmodule

module morra_giocatore #(
  parameter logic [7:0] SEED1      = 8'hA5,
  parameter logic [7:0] SEED2      = 8'h3C,
  parameter int         MAX_MANCHE = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  morra_giocatore_if.master  bus
);
  localparam int NUM_PLAYERS = 2;
  localparam logic [NUM_PLAYERS-1:0][7:0] SEEDS = {SEED2, SEED1};
  localparam logic [3:0] MAXN = 4'(MAX_MANCHE);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0] state;

  logic [NUM_PLAYERS-1:0][1:0] mv;      // next moves from the lanes
  logic [NUM_PLAYERS-1:0][1:0] mv_q;    // registered move outputs
  logic [NUM_PLAYERS-1:0][1:0] play_q;  // moves of the round being judged
  logic [NUM_PLAYERS-1:0][1:0] prev_q, prev_d;
  logic [NUM_PLAYERS-1:0]      rule;
  logic [1:0] win_q, win_d;             // 01 P1, 10 P2, else nobody
  logic       inizio_q, fine_q, to_q;
  logic [1:0] vinc_q;
  logic [3:0] n_q, n_d;
  logic       valid, go_play;

  assign valid = (bus.manche != 2'b00);

  // Round bookkeeping as it will stand after the current edge. The move for
  // the next PLAY is chosen at the same edge that ends CHECK, so the
  // no-repeat rule must see the freshly judged round, not the stale one.
  assign win_d  = (state == CHECK && valid) ? bus.manche : win_q;
  assign prev_d = (state == CHECK && valid) ? play_q     : prev_q;
  assign n_d    = (state == CHECK && valid && n_q != 4'd15) ? n_q + 4'd1 : n_q;

  assign go_play = (state == START) ||
                   (state == CHECK && bus.partita == 2'b00 && n_d != MAXN);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pl
    assign rule[g] = (win_d == 2'(g + 1));
    morra_lfsr_player #(.SEED(SEEDS[g])) u_pl (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (go_play),
      .hold_rule (rule[g]),
      .prev_mv   (prev_d[g]),
      .mv        (mv[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mv_q     <= '0;
      play_q   <= '0;
      prev_q   <= '0;
      win_q    <= 2'b00;
      inizio_q <= 1'b0;
      fine_q   <= 1'b0;
      vinc_q   <= 2'b00;
      n_q      <= 4'd0;
      to_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.avvia) begin
            state    <= START;
            inizio_q <= 1'b1;
            mv_q     <= '0;
            prev_q   <= '0;
            win_q    <= 2'b00;
            fine_q   <= 1'b0;
            vinc_q   <= 2'b00;
            n_q      <= 4'd0;
            to_q     <= 1'b0;
          end
        end
        START: begin
          state    <= PLAY;
          inizio_q <= 1'b0;
          mv_q     <= mv;
          play_q   <= mv;
        end
        PLAY: begin
          // referee ignores 00 moves, so CHECK is a quiet cycle
          state <= CHECK;
          mv_q  <= '0;
        end
        CHECK: begin
          n_q    <= n_d;
          win_q  <= win_d;
          prev_q <= prev_d;
          if (bus.partita != 2'b00) begin
            state  <= DONE;
            fine_q <= 1'b1;
            vinc_q <= bus.partita;
          end else if (n_d == MAXN) begin
            state  <= DONE;
            fine_q <= 1'b1;
            to_q   <= 1'b1;
            vinc_q <= 2'b00;
          end else begin
            state  <= PLAY;
            mv_q   <= mv;
            play_q <= mv;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.primo     = mv_q[0];
  assign bus.secondo   = mv_q[1];
  assign bus.inizio    = inizio_q;
  assign bus.fine      = fine_q;
  assign bus.vincitore = vinc_q;
  assign bus.n_manche  = n_q;
  assign bus.timeout   = to_q;
endmodule
